// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries; flush wins over push.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC ownership, capped memory requests, redirect flush.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFETCH_RESET_PC,
  parameter int          QDEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [29:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int CW = cnt_w(QDEPTH);
  localparam logic [CW:0] CAP = (CW+1)'(QDEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  fetch_entry_t  q_head, push_entry;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty;
  logic [CW:0]   occupancy;
  logic          req_fire, rsp_keep, pop;
  logic [31:0]   redirect_base;
  logic          unused_ok;

  assign occupancy      = {1'b0, inflight_q} + {1'b0, q_count};
  assign imem_req_valid = !RST && (occupancy < CAP);
  assign imem_req_addr  = fetch_pc_q[31:2];
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect;
  assign pop            = instr_valid && instr_ready;
  assign redirect_base  = {redirect_pc[31:2], 2'b00};
  assign push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

  assign instr_valid   = !q_empty;
  assign instr         = q_head.instr;
  assign instr_pc      = q_head.pc;
  assign instr_pcplus4 = q_head.pc + 32'd4;

  assign unused_ok = ^{redirect_pc[1:0], q_full};

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (rsp_keep),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      // Everything still outstanding after this cycle belongs to the old path.
      drop_d     = inflight_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (instr_ready && !instr_valid) perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  // No counters in this build.
`endif

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: memory model and monitor on the falling edge.
module tb_ifetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [29:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr, instr_pc, instr_pcplus4;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  always #5 CLK = ~CLK;

  ifetch dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pcplus4  (instr_pcplus4),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  typedef struct {
    logic [29:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] sb[$];
  int          cyc, acc_cnt, pop_cnt, bubble_cnt, max_occ, mem_lat;
  bit          occ_en;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Memory model (in-order, fixed latency per request) followed by the monitor.
  always @(negedge CLK) begin
    mreq_t       r;
    logic [31:0] exp_pc;
    if (RST) begin
      memq.delete();
      cyc = 0; acc_cnt = 0; pop_cnt = 0; bubble_cnt = 0; max_occ = 0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
    end else begin
      cyc++;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      imem_req_ready = 1'b1;
      if (imem_req_valid) begin
        r.addr = imem_req_addr;
        r.due  = cyc + mem_lat;
        memq.push_back(r);
        acc_cnt++;
      end
      if (occ_en && (acc_cnt - pop_cnt) > max_occ) max_occ = acc_cnt - pop_cnt;
      if (instr_ready && !instr_valid) bubble_cnt++;
      if (instr_valid && instr_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pop: got pc %h, required no pop", instr_pc);
        end else begin
          exp_pc = sb.pop_front();
          check("pop_pc", instr_pc, exp_pc);
          check("pop_instr", instr, mem_word(exp_pc[31:2]));
          check("pop_pcplus4", instr_pcplus4, exp_pc + 32'd4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int lat);
    RST = 1'b1; instr_ready = 1'b0; redirect = 1'b0; mem_lat = lat;
    tick();
    @(negedge CLK);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
`ifdef IFETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
    @(posedge CLK);
    #1;
    sb.delete();
    occ_en = 1'b1;
    RST = 1'b0;
  endtask

  task automatic run_pops(input int target, input int budget);
    instr_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (pop_cnt >= target) break;
      tick();
    end
    instr_ready = 1'b0;
    check("pop_count", 32'(pop_cnt), 32'(target));
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_lat = 1; occ_en = 1'b0;

    // Streaming from reset with 1-cycle memory.
    do_reset(1);
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) sb.push_back(32'(4 * i));
    @(negedge CLK);
    check("s1_req_valid", 32'(imem_req_valid), 32'd1);
    check("s1_addr0", 32'(imem_req_addr), 32'd0);
    check("s1_valid_c0", 32'(instr_valid), 32'd0);
    tick(); @(negedge CLK);
    check("s1_addr1", 32'(imem_req_addr), 32'd1);
    check("s1_valid_c1", 32'(instr_valid), 32'd0);
    tick(); @(negedge CLK);
    check("s1_addr2", 32'(imem_req_addr), 32'd2);
    check("s1_valid_c2", 32'(instr_valid), 32'd1);
    tick();
    run_pops(12, 50);
    check("s1_bubbles", 32'(bubble_cnt), 32'd2);

    // Latency 3: cap on queued plus in-flight, no loss or duplication.
    do_reset(3);
    for (int i = 0; i < 16; i++) sb.push_back(32'(4 * i));
    run_pops(16, 200);
    check("s2_max_occ_le4", 32'(max_occ <= 4), 32'd1);

    // Stalled datapath for 10 cycles.
    do_reset(1);
    repeat (9) tick();
    @(negedge CLK);
    check("s3_acc_cnt", 32'(acc_cnt), 32'd4);
    check("s3_req_valid_off", 32'(imem_req_valid), 32'd0);
    check("s3_instr_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 4; i++) sb.push_back(32'(4 * i));
    tick();
    run_pops(4, 20);

    // Redirect with 2 in flight and 2 queued.
    do_reset(3);
    occ_en = 1'b0;
    repeat (5) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100; mem_lat = 1;
    tick();
    redirect = 1'b0;
    @(negedge CLK);
    check("s4_valid_r1", 32'(instr_valid), 32'd0);
    check("s4_req_addr", 32'(imem_req_addr), 32'h40);
    tick(); @(negedge CLK);
    check("s4_valid_r2", 32'(instr_valid), 32'd0);
    tick(); @(negedge CLK);
    check("s4_valid_r3", 32'(instr_valid), 32'd1);
    check("s4_pc_r3", instr_pc, 32'h0000_0100);
    for (int i = 0; i < 6; i++) sb.push_back(32'h100 + 32'(4 * i));
    tick();
    run_pops(6, 40);

    // Redirect coinciding with a response and a pop; unaligned target.
    do_reset(1);
    occ_en = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(32'(4 * i));
    for (int i = 0; i < 6; i++) sb.push_back(32'h200 + 32'(4 * i));
    repeat (5) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    @(negedge CLK);
    check("s5_req_addr", 32'(imem_req_addr), 32'h80);
    check("s5_pops_at_r", 32'(pop_cnt), 32'd4);
    tick();
    run_pops(10, 40);
    check("s5_bubbles", 32'(bubble_cnt), 32'd4);
`ifdef IFETCH_PERF_EN
    check("s5_perf_fetched", perf_fetched, 32'(pop_cnt));
    check("s5_perf_bubbles", perf_bubbles, 32'(bubble_cnt));
`endif

    // PC wrap past 0xFFFF_FFFC.
    do_reset(1);
    occ_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    @(negedge CLK);
    check("s6_addr_top", 32'(imem_req_addr), 32'h3FFF_FFFF);
    tick(); @(negedge CLK);
    check("s6_addr_wrap", 32'(imem_req_addr), 32'h0);
    sb.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) sb.push_back(32'(4 * i));
    tick();
    run_pops(4, 30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
